// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite blitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sprite_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic MODE_DRAW = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    localparam int SCR_W_DEF = 160;
    localparam int SCR_H_DEF = 120;
    localparam int CW_DEF    = 3;

endpackage

// File: rtl/sprite_pipe_delay.sv
// Fixed-depth shift register with synchronous clear; keeps pixel tags aligned with ROM data.
// Latency: DEPTH cycles from din to dout.
// Backpressure: none; shifts every cycle, clr empties every stage on the next edge.
// Ports: CLOCK_50/Resetn (sync, active-low), clr, din[W], dout[W].
module sprite_pipe_delay #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         CLOCK_50,
    input  logic         Resetn,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_q [DEPTH];
    logic [W-1:0] stage_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = '0;
        end
        if (!clr) begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/sprite_blitter.sv
// Walks a SPR_W x SPR_H sprite, fetches pixels from a fixed-latency ROM and emits one VGA plot beat per pixel.
// Latency: pixel k address in cycle k+1, pixel k output in cycle k+ROM_LAT+2; blit takes N+ROM_LAT+3 cycles.
// Backpressure: none; start is only taken in IDLE, abort cancels any active blit on the next edge.
// Ports: CLOCK_50, Resetn (sync, active-low); request start/abort/x0/y0/base_addr/mode/fill_colour;
//        status busy/done; ROM rom_addr/rom_data; VGA vga_x/vga_y/vga_colour/vga_plot.
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int           XW         = 8,
    parameter int           YW         = 7,
    parameter int           CW         = CW_DEF,
    parameter int           AW         = 13,
    parameter int           SPR_W      = 24,
    parameter int           SPR_H      = 74,
    parameter int           SCR_W      = SCR_W_DEF,
    parameter int           SCR_H      = SCR_H_DEF,
    parameter int           ROM_LAT    = 1,
    parameter int           KEY_EN     = 1,
    parameter logic [CW-1:0] KEY_COLOUR = '0
) (
    input  logic          CLOCK_50,
    input  logic          Resetn,
    input  logic          start,
    input  logic          abort,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [AW-1:0] base_addr,
    input  logic          mode,
    input  logic [CW-1:0] fill_colour,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rom_addr,
    input  logic [CW-1:0] rom_data,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [CW-1:0] vga_colour,
    output logic          vga_plot
);

    localparam int XCW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int YCW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int DCW = $clog2(ROM_LAT + 2);
    localparam int PW  = 1 + XCW + YCW;

    state_t          state_q, state_d;
    logic [XW-1:0]   x0_q, x0_d;
    logic [YW-1:0]   y0_q, y0_d;
    logic            mode_q, mode_d;
    logic [CW-1:0]   fill_q, fill_d;
    logic [XCW-1:0]  xc_q, xc_d;
    logic [YCW-1:0]  yc_q, yc_d;
    logic [DCW-1:0]  dcnt_q, dcnt_d;
    logic [AW-1:0]   rom_addr_q, rom_addr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [XW-1:0]   vga_x_q, vga_x_d;
    logic [YW-1:0]   vga_y_q, vga_y_d;
    logic [CW-1:0]   vga_colour_q, vga_colour_d;
    logic            vga_plot_q, vga_plot_d;

    logic            issue;
    logic            abort_hit;
    logic [PW-1:0]   pipe_out;
    logic            p_vld;
    logic [XCW-1:0]  p_xc;
    logic [YCW-1:0]  p_yc;
    logic [XW:0]     x_sum;
    logic [YW:0]     y_sum;
    logic            clipped;
    logic            keyed;

    // abort only has an effect once a blit has been accepted
    assign abort_hit = abort && (state_q != ST_IDLE);

    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        mode_d     = mode_q;
        fill_d     = fill_q;
        xc_d       = xc_q;
        yc_d       = yc_q;
        dcnt_d     = dcnt_q;
        rom_addr_d = rom_addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        issue      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    x0_d       = x0;
                    y0_d       = y0;
                    mode_d     = mode;
                    fill_d     = fill_colour;
                    xc_d       = '0;
                    yc_d       = '0;
                    rom_addr_d = base_addr;
                    busy_d     = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                issue      = 1'b1;
                rom_addr_d = rom_addr_q + AW'(1);
                if (xc_q == XCW'(SPR_W - 1)) begin
                    xc_d = '0;
                    if (yc_q == YCW'(SPR_H - 1)) begin
                        dcnt_d  = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        yc_d = yc_q + YCW'(1);
                    end
                end else begin
                    xc_d = xc_q + XCW'(1);
                end
            end
            ST_DRAIN: begin
                // last pixel leaves the ROM pipe and output register after ROM_LAT+1 cycles
                if (dcnt_q == DCW'(ROM_LAT)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    dcnt_d = dcnt_q + DCW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_hit) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    sprite_pipe_delay #(
        .W     (PW),
        .DEPTH (ROM_LAT)
    ) u_pipe (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .clr      (abort_hit),
        .din      ({issue, xc_q, yc_q}),
        .dout     (pipe_out)
    );

    assign {p_vld, p_xc, p_yc} = pipe_out;

    // sums are one bit wider so an off-screen pixel cannot wrap back on screen
    always_comb begin
        x_sum        = {1'b0, x0_q} + (XW+1)'(p_xc);
        y_sum        = {1'b0, y0_q} + (YW+1)'(p_yc);
        clipped      = (x_sum >= (XW+1)'(SCR_W)) || (y_sum >= (YW+1)'(SCR_H));
        keyed        = (KEY_EN != 0) && (mode_q == MODE_DRAW) && (rom_data == KEY_COLOUR);
        vga_x_d      = x_sum[XW-1:0];
        vga_y_d      = y_sum[YW-1:0];
        vga_colour_d = (mode_q == MODE_FILL) ? fill_q : rom_data;
        vga_plot_d   = p_vld && !clipped && !keyed && !abort_hit;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_q      <= ST_IDLE;
            x0_q         <= '0;
            y0_q         <= '0;
            mode_q       <= 1'b0;
            fill_q       <= '0;
            xc_q         <= '0;
            yc_q         <= '0;
            dcnt_q       <= '0;
            rom_addr_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            mode_q       <= mode_d;
            fill_q       <= fill_d;
            xc_q         <= xc_d;
            yc_q         <= yc_d;
            dcnt_q       <= dcnt_d;
            rom_addr_q   <= rom_addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rom_addr   = rom_addr_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: three instances (2x2 keyed lat1, 24x74 lat3, 2x2 unkeyed lat1) share one ROM image.
// Expected beats come from a per-pixel model of the sprite rectangle, clip and key rules.
module tb_sprite_blitter;

    logic        CLOCK_50 = 1'b0;
    logic        Resetn   = 1'b0;
    logic [7:0]  tb_x0    = '0;
    logic [6:0]  tb_y0    = '0;
    logic [12:0] tb_base  = '0;
    logic        tb_mode  = 1'b0;
    logic [2:0]  tb_fill  = '0;
    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic        abort_a = 1'b0, abort_b = 1'b0, abort_c = 1'b0;

    logic        busy_a, busy_b, busy_c, done_a, done_b, done_c, plot_a, plot_b, plot_c;
    logic [12:0] addr_a, addr_b, addr_c;
    logic [7:0]  vx_a, vx_b, vx_c;
    logic [6:0]  vy_a, vy_b, vy_c;
    logic [2:0]  col_a, col_b, col_c;
    logic [2:0]  rd_a, rd_b, rd_c, rb1, rb2;

    logic [2:0]  rom_mem [0:8191];

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    // ROM models: latency 1 for a/c, latency 3 for b
    always @(posedge CLOCK_50) begin
        rd_a <= rom_mem[addr_a];
        rd_c <= rom_mem[addr_c];
        rb1  <= rom_mem[addr_b];
        rb2  <= rb1;
        rd_b <= rb2;
    end

    sprite_blitter #(.SPR_W(2), .SPR_H(2), .ROM_LAT(1), .KEY_EN(1)) dut_a (
        .CLOCK_50(CLOCK_50), .Resetn(Resetn), .start(start_a), .abort(abort_a),
        .x0(tb_x0), .y0(tb_y0), .base_addr(tb_base), .mode(tb_mode), .fill_colour(tb_fill),
        .busy(busy_a), .done(done_a), .rom_addr(addr_a), .rom_data(rd_a),
        .vga_x(vx_a), .vga_y(vy_a), .vga_colour(col_a), .vga_plot(plot_a));

    sprite_blitter #(.SPR_W(24), .SPR_H(74), .ROM_LAT(3), .KEY_EN(1)) dut_b (
        .CLOCK_50(CLOCK_50), .Resetn(Resetn), .start(start_b), .abort(abort_b),
        .x0(tb_x0), .y0(tb_y0), .base_addr(tb_base), .mode(tb_mode), .fill_colour(tb_fill),
        .busy(busy_b), .done(done_b), .rom_addr(addr_b), .rom_data(rd_b),
        .vga_x(vx_b), .vga_y(vy_b), .vga_colour(col_b), .vga_plot(plot_b));

    sprite_blitter #(.SPR_W(2), .SPR_H(2), .ROM_LAT(1), .KEY_EN(0)) dut_c (
        .CLOCK_50(CLOCK_50), .Resetn(Resetn), .start(start_c), .abort(abort_c),
        .x0(tb_x0), .y0(tb_y0), .base_addr(tb_base), .mode(tb_mode), .fill_colour(tb_fill),
        .busy(busy_c), .done(done_c), .rom_addr(addr_c), .rom_data(rd_c),
        .vga_x(vx_c), .vga_y(vy_c), .vga_colour(col_c), .vga_plot(plot_c));

    // observation mux for the instance under test
    int          sel = 0;
    logic        o_busy, o_done, o_plot;
    logic [12:0] o_addr;
    logic [7:0]  o_x;
    logic [6:0]  o_y;
    logic [2:0]  o_col;

    always_comb begin
        case (sel)
            0:       begin o_busy = busy_a; o_done = done_a; o_plot = plot_a; o_addr = addr_a; o_x = vx_a; o_y = vy_a; o_col = col_a; end
            1:       begin o_busy = busy_b; o_done = done_b; o_plot = plot_b; o_addr = addr_b; o_x = vx_b; o_y = vy_b; o_col = col_b; end
            default: begin o_busy = busy_c; o_done = done_c; o_plot = plot_c; o_addr = addr_c; o_x = vx_c; o_y = vy_c; o_col = col_c; end
        endcase
    end

    function automatic int spr_w(input int d); return (d == 1) ? 24 : 2; endfunction
    function automatic int spr_h(input int d); return (d == 1) ? 74 : 2; endfunction
    function automatic int lat(input int d);   return (d == 1) ? 3 : 1;  endfunction
    function automatic bit key_en(input int d); return (d != 2); endfunction

    task automatic set_start(input int d, input logic v);
        case (d)
            0:       start_a = v;
            1:       start_b = v;
            default: start_c = v;
        endcase
    endtask

    task automatic set_abort(input int d, input logic v);
        case (d)
            0:       abort_a = v;
            1:       abort_b = v;
            default: abort_c = v;
        endcase
    endtask

    // One blit on instance d. Cycle 0 is the cycle start is high; every later cycle is compared to the model.
    // abort_cyc>0 aborts in that cycle; poke_done pulses start during the DONE cycle.
    task automatic run_blit(input int d, input int ax, input int ay, input int abase, input bit amode,
                            input int afill, input int abort_cyc, input bit poke_done, input string tag);
        int w, h, l, n, last, k, xs, ys, col, beats_exp, beats_got;
        bit aborted, ex_busy, ex_done, ex_plot, in_win;
        w = spr_w(d); h = spr_h(d); l = lat(d); n = w * h;
        last = (abort_cyc > 0) ? abort_cyc + 1 : (poke_done ? n + l + 4 : n + l + 2);
        beats_exp = 0; beats_got = 0;
        sel = d;
        @(negedge CLOCK_50);
        tb_x0 = 8'(ax); tb_y0 = 7'(ay); tb_base = 13'(abase); tb_mode = amode; tb_fill = 3'(afill);
        set_start(d, 1'b1);
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s idle_busy cyc=0 got=%b exp=0", tag, o_busy);
        end
        for (int c = 1; c <= last; c++) begin
            @(negedge CLOCK_50);
            aborted = (abort_cyc > 0) && (c > abort_cyc);
            ex_busy = !aborted && (c <= n + l + 1);
            ex_done = !aborted && (c == n + l + 2);
            k       = c - l - 2;
            in_win  = !aborted && (k >= 0) && (k < n);
            ex_plot = 1'b0;
            xs = 0; ys = 0; col = 0;
            if (in_win) begin
                xs  = ax + (k % w);
                ys  = ay + (k / w);
                col = amode ? afill : int'(rom_mem[(abase + k) % 8192]);
                ex_plot = (xs < 160) && (ys < 120) && !(key_en(d) && !amode && col == 0);
            end
            if (ex_plot) beats_exp++;
            if (o_plot === 1'b1) beats_got++;

            n_checks++;
            if (o_busy !== ex_busy) begin
                n_errors++;
                $display("FAIL %s busy cyc=%0d got=%b exp=%b", tag, c, o_busy, ex_busy);
            end
            n_checks++;
            if (o_done !== ex_done) begin
                n_errors++;
                $display("FAIL %s done cyc=%0d got=%b exp=%b", tag, c, o_done, ex_done);
            end
            n_checks++;
            if (o_plot !== ex_plot) begin
                n_errors++;
                $display("FAIL %s plot cyc=%0d got=%b exp=%b", tag, c, o_plot, ex_plot);
            end
            if (in_win) begin
                n_checks++;
                if (o_x !== 8'(xs) || o_y !== 7'(ys) || o_col !== 3'(col)) begin
                    n_errors++;
                    $display("FAIL %s pixel cyc=%0d got=(%0d,%0d)c%0d exp=(%0d,%0d)c%0d",
                             tag, c, o_x, o_y, o_col, 8'(xs), 7'(ys), col);
                end
            end
            if (!aborted && c <= n) begin
                n_checks++;
                if (o_addr !== 13'((abase + c - 1) % 8192)) begin
                    n_errors++;
                    $display("FAIL %s rom_addr cyc=%0d got=%0d exp=%0d", tag, c, o_addr, (abase + c - 1) % 8192);
                end
            end
            set_start(d, poke_done && (c == n + l + 2));
            set_abort(d, c == abort_cyc);
        end
        set_start(d, 1'b0);
        set_abort(d, 1'b0);
        if (abort_cyc == 0) begin
            n_checks++;
            if (beats_got != beats_exp) begin
                n_errors++;
                $display("FAIL %s beat_count got=%0d exp=%0d", tag, beats_got, beats_exp);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 3; d++) begin
            sel = d;
            #1;
            n_checks++;
            if ({o_busy, o_done, o_plot, o_addr, o_x, o_y, o_col} !== '0) begin
                n_errors++;
                $display("FAIL %s dut%0d got busy=%b done=%b plot=%b addr=%0d x=%0d y=%0d col=%0d exp all 0",
                         tag, d, o_busy, o_done, o_plot, o_addr, o_x, o_y, o_col);
            end
        end
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check_all_zero("reset");
        Resetn = 1'b1;
    endtask

    task automatic test_basic_draw();
        rom_mem[0] = 3'd1; rom_mem[1] = 3'd2; rom_mem[2] = 3'd3; rom_mem[3] = 3'd4;
        run_blit(0, 10, 20, 0, 1'b0, 0, 0, 1'b0, "basic");
    endtask

    task automatic test_colour_key();
        rom_mem[1] = 3'd0;
        run_blit(0, 10, 20, 0, 1'b0, 0, 0, 1'b0, "key_on");
        run_blit(2, 10, 20, 0, 1'b0, 0, 0, 1'b0, "key_off");
    endtask

    task automatic test_clip_fill();
        run_blit(0, 159, 119, 0, 1'b1, 5, 0, 1'b0, "clip_fill");
    endtask

    task automatic test_long_lat3();
        for (int i = 0; i < 1776; i++) rom_mem[100 + i] = 3'(1 + (i % 7));
        run_blit(1, 0, 0, 100, 1'b0, 0, 0, 1'b0, "long");
    endtask

    task automatic test_abort();
        run_blit(1, 3, 4, 500, 1'b0, 0, 10, 1'b0, "abort");
        run_blit(1, 140, 50, 8000, 1'b0, 0, 0, 1'b0, "after_abort");
    endtask

    task automatic test_abort_start_idle();
        sel = 0;
        @(negedge CLOCK_50);
        start_a = 1'b1; abort_a = 1'b1;
        @(negedge CLOCK_50);
        start_a = 1'b0; abort_a = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (o_busy !== 1'b0 || o_plot !== 1'b0) begin
                n_errors++;
                $display("FAIL abort_idle cyc=%0d got busy=%b plot=%b exp 0 0", c, o_busy, o_plot);
            end
            @(negedge CLOCK_50);
        end
    endtask

    task automatic test_reset_mid_run();
        sel = 1;
        @(negedge CLOCK_50);
        tb_x0 = 8'd5; tb_y0 = 7'd5; tb_base = 13'd42; tb_mode = 1'b0;
        start_b = 1'b1;
        @(negedge CLOCK_50);
        start_b = 1'b0;
        repeat (20) @(negedge CLOCK_50);
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_run_busy got=%b exp=1", o_busy);
        end
        Resetn = 1'b0;
        @(negedge CLOCK_50);
        check_all_zero("mid_reset");
        Resetn = 1'b1;
        run_blit(0, 30, 40, 7, 1'b0, 0, 0, 1'b1, "start_in_done");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            int d;
            d = (i % 2 == 0) ? 0 : 2;
            run_blit(d, $urandom_range(0, 1) ? int'($urandom_range(150, 160)) : int'($urandom_range(0, 255)),
                     int'($urandom_range(100, 127)), (i == 3) ? 8190 : int'($urandom_range(0, 8191)),
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 0, 1'b0, "b2b_rand");
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) rom_mem[i] = 3'($urandom);
        test_reset();
        test_basic_draw();
        test_colour_key();
        test_clip_fill();
        test_back_to_back();
        test_abort_start_idle();
        test_long_lat3();
        test_abort();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
